keypad_hex_entry: RTL and testbench
===================================

KEYPAD_HEX_ENTRY -- requirements
Module: keypad_hex_entry

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, meaning the number of CLK cycles per scan tick (allowed range 2..2^20).
REQ-002 SHALL provide parameter DEBOUNCE_TICKS, default 4, meaning the number of consecutive stable ticks needed to accept a press or a release (allowed range 1..15).
REQ-003 SHALL provide parameter REPEAT_TICKS, default 100, meaning the number of ticks between auto-repeat pulses (used only when auto-repeat is compiled in).
REQ-004 Port CLK, input, 1 bit: the single system clock, rising edge.
REQ-005 Port clr, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port row_in, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to CLK.
REQ-007 Port col_out, output, 4 bits: column strobe, exactly one bit low at all times.
REQ-008 Port key_valid, output, 1 bit: one-CLK pulse for each accepted key.
REQ-009 Port key_code, output, 4 bits: code of the last accepted key.
REQ-010 Port entry_value, output, 16 bits: the four most recent hex digits, newest digit in bits [3:0].

Function
REQ-011 Pass row_in through a 2-flop synchronizer before any use; logic SHALL see rows only in this synchronized form.
REQ-012 Tick divider: pulse the internal tick for one cycle every SCAN_DIV cycles; the divider wraps from SCAN_DIV-1 to 0.
REQ-013 Key code = {row_idx[1:0], col_idx[1:0]}; index 0 = bit 0 of the port.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: on each tick, sample the rows. If any row is low, latch row_idx (lowest low row wins) and col_idx, and go to DEBOUNCE. Otherwise rotate col_out left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
REQ-016 DEBOUNCE: col_out is held. On each tick where the latched row is still low, increment the stable counter. The latched row reading high returns the FSM to SCAN with col_out unchanged.
REQ-017 When the stable counter reaches DEBOUNCE_TICKS, on the next CLK: key_valid=1, key_code=code, entry_value={entry_value[11:0], code}, state=HELD.
REQ-018 HELD: on a tick where the latched row reads high, go to RELEASE with the counter cleared.
REQ-019 RELEASE: count consecutive high ticks. A low reading returns to HELD without a new pulse. DEBOUNCE_TICKS consecutive high ticks go to SCAN, and scanning resumes from the next column.
REQ-020 Other keys pressed while in DEBOUNCE/HELD/RELEASE are ignored (no rollover).
REQ-021 key_valid is never high for two consecutive cycles.
REQ-022 key_code and entry_value change only in the cycle key_valid is high.

Reset
REQ-023 While clr=1 at a CLK edge, the block SHALL set: state=SCAN, col_out=4'b1110, key_valid=0, key_code=0, entry_value=16'h0000, divider/counters=0, synchronizer flops=4'hF.
REQ-024 clr asserted mid-press SHALL abort the press without a pulse. A key still held after clr deasserts SHALL be accepted again through the full debounce.

Configuration
REQ-025 Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, once the latched row has stayed low for REPEAT_TICKS ticks, emit a key_valid pulse with the same code and shift it into entry_value. This repeats every REPEAT_TICKS ticks until release.
- Undefined: exactly one pulse per press, and REPEAT_TICKS has no effect.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the FSM state enum, the column-strobe reset constant 4'b1110, and the key-code width 4.
REQ-027 Sub-module keypad_tick_gen SHALL implement the SCAN_DIV divider with a tick output. The FSM, synchronizer and entry register stay in the top module.

Verification (bench parameters SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5)
REQ-028 Reset: after clr=1 for 2 cycles -> col_out=1110, entry_value=0000, key_valid=0. col_out then rotates every 4 cycles.
REQ-029 Stable press, row 2 low while col_out=1101 -> exactly one key_valid pulse, key_code=4'h9. It occurs on the cycle after the 3rd stable tick.
REQ-030 Four presses (codes 1, 2, 3, 4), each released cleanly -> entry_value=16'h1234. A fifth press of F -> entry_value=16'h234F.
REQ-031 Bounce: row low for 2 ticks, high for 1, low for 3 -> exactly one pulse. Release chatter of 1 high tick then low -> no extra pulse.
REQ-032 Two rows low at once (rows 1 and 3, column 0) -> key_code=4'h4. clr asserted during DEBOUNCE -> no pulse; the held key is accepted after clr deasserts.
REQ-033 With KEYPAD_AUTOREPEAT_EN, key 7 held for 17 ticks after acceptance -> 4 pulses in total. Without the macro -> 1 pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad entry block.
package keypad_pkg;

    localparam int         KEY_W   = 4;
    localparam logic [3:0] COL_RST = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kp_state_e;

    // Index of the lowest zero bit; lowest active-low line wins.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!v[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick divider: one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (clr)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner with debounce and a 4-digit entry shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic [15:0]      entry_value
);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic             tick;
    logic [3:0]       sync1, rows;
    kp_state_e        state;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       stable_cnt;
    logic [RW-1:0]    rep_cnt;
    logic             row_low;
    logic             rep_hit;
    logic [KEY_W-1:0] code;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (CLK),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (clr) begin
            sync1 <= 4'hF;
            rows  <= 4'hF;
        end else begin
            sync1 <= row_in;
            rows  <= sync1;
        end
    end

    assign row_low = ~rows[row_idx];
    assign code    = {row_idx, col_idx};
    assign rep_hit = AUTOREPEAT && (rep_cnt == RW'(REPEAT_TICKS - 1));

    always_ff @(posedge CLK) begin
        if (clr) begin
            state       <= ST_SCAN;
            col_out     <= COL_RST;
            key_valid   <= 1'b0;
            key_code    <= '0;
            entry_value <= 16'h0000;
            row_idx     <= 2'd0;
            col_idx     <= 2'd0;
            stable_cnt  <= 4'd0;
            rep_cnt     <= '0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (rows != 4'hF) begin
                            row_idx    <= low_index(rows);
                            col_idx    <= low_index(col_out);
                            stable_cnt <= 4'd0;
                            state      <= ST_DEBOUNCE;
                        end else begin
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!row_low) begin
                            state <= ST_SCAN;
                        end else if (stable_cnt == 4'(DEBOUNCE_TICKS - 1)) begin
                            key_valid   <= 1'b1;
                            key_code    <= code;
                            entry_value <= {entry_value[11:0], code};
                            stable_cnt  <= 4'd0;
                            rep_cnt     <= '0;
                            state       <= ST_HELD;
                        end else begin
                            stable_cnt <= stable_cnt + 4'd1;
                        end
                    end
                    ST_HELD: begin
                        if (!row_low) begin
                            stable_cnt <= 4'd0;
                            state      <= ST_RELEASE;
                        end else if (rep_hit) begin
                            key_valid   <= 1'b1;
                            key_code    <= code;
                            entry_value <= {entry_value[11:0], code};
                            rep_cnt     <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        // Release chatter goes back to HELD; repeat timing restarts.
                        if (row_low) begin
                            rep_cnt <= '0;
                            state   <= ST_HELD;
                        end else if (stable_cnt == 4'(DEBOUNCE_TICKS - 1)) begin
                            col_out <= {col_out[2:0], col_out[3]};
                            state   <= ST_SCAN;
                        end else begin
                            stable_cnt <= stable_cnt + 4'd1;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a 4x4 switch-matrix keypad model.
module tb_keypad_hex_entry;

    logic        CLK = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_value;

    keypad_hex_entry #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3),
        .REPEAT_TICKS  (5)
    ) dut (
        .CLK        (CLK),
        .clr        (clr),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry_value(entry_value)
    );

    always #5 CLK = ~CLK;

    // pressed[r][c]: a closed switch pulls row r low while column c is strobed.
    logic [3:0][3:0] pressed = '0;
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r] & ~col_out);
    end

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int pulses = 0;
    int pulse_ecnt = -1;
    int doubles = 0;
    int strays = 0;
    bit mon_en = 1'b0;
    logic        prev_kv = 1'b0;
    logic [3:0]  prev_code = '0;
    logic [15:0] prev_entry = '0;

    always @(posedge CLK) begin
        if (clr) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            if (key_valid === 1'b1) begin
                pulses++;
                pulse_ecnt = ecnt;
                if (prev_kv === 1'b1) doubles++;
            end else if (ecnt != 0 && (key_code !== prev_code || entry_value !== prev_entry)) begin
                strays++;
            end
        end
        prev_kv    = key_valid;
        prev_code  = key_code;
        prev_entry = entry_value;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        clr = 1'b0;
        mon_en = 1'b1;
        #1;
    endtask

    // Returns just after the negedge that follows the next scan-tick edge.
    task automatic next_tick();
        @(negedge CLK);
        while (ecnt % 4 != 0) @(negedge CLK);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    task automatic wait_pulse(input int base, input int max_ticks);
        for (int i = 0; i < max_ticks && pulses == base; i++) next_tick();
        chk("pulse_seen", 32'(pulses > base), 32'd1);
    endtask

    typedef struct {
        int          r;
        int          c;
        logic [3:0]  code;
        logic [15:0] entry;
    } vec_t;

    vec_t vt[5];
    int   base;

    initial begin
        vt[0] = '{0, 1, 4'h1, 16'h0001};
        vt[1] = '{0, 2, 4'h2, 16'h0012};
        vt[2] = '{0, 3, 4'h3, 16'h0123};
        vt[3] = '{1, 0, 4'h4, 16'h1234};
        vt[4] = '{3, 3, 4'hF, 16'h234F};

        // Reset values and column rotation cadence
        do_reset();
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_entry", 32'(entry_value), 32'h0);
        chk("rst_kv", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        repeat (3) @(negedge CLK);
        chk("col_before_tick", 32'(col_out), 32'hE);
        next_tick();
        chk("col_tick1", 32'(col_out), 32'hD);
        next_tick();
        chk("col_tick2", 32'(col_out), 32'hB);

        // Stable press, row 2 / column 1
        do_reset();
        base = pulses;
        pressed[2][1] = 1'b1;
        wait_pulse(base, 12);
        chk("stable_code", 32'(key_code), 32'h9);
        chk("stable_when", 32'(pulse_ecnt), 32'd20);
        chk("stable_entry", 32'(entry_value), 32'h0009);
        pressed = '0;
        wait_ticks(6);
        chk("stable_count", 32'(pulses - base), 32'd1);

        // Table of sequential keys building the entry register
        do_reset();
        for (int i = 0; i < 5; i++) begin
            base = pulses;
            pressed[vt[i].r][vt[i].c] = 1'b1;
            wait_pulse(base, 12);
            chk("tbl_code", 32'(key_code), 32'(vt[i].code));
            chk("tbl_entry", 32'(entry_value), 32'(vt[i].entry));
            pressed = '0;
            wait_ticks(6);
            chk("tbl_count", 32'(pulses - base), 32'd1);
        end

        // Press bounce, then release chatter
        do_reset();
        base = pulses;
        pressed[0][0] = 1'b1;
        wait_ticks(2);
        pressed = '0;
        next_tick();
        chk("bounce_no_pulse", 32'(pulses - base), 32'd0);
        pressed[0][0] = 1'b1;
        wait_pulse(base, 8);
        chk("bounce_when", 32'(pulse_ecnt), 32'd28);
        chk("bounce_code", 32'(key_code), 32'h0);
        pressed = '0;
        next_tick();
        pressed[0][0] = 1'b1;
        wait_ticks(2);
        pressed = '0;
        wait_ticks(6);
        chk("chatter_count", 32'(pulses - base), 32'd1);

        // Two rows in one column: lowest row wins
        do_reset();
        base = pulses;
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        wait_pulse(base, 12);
        chk("multi_code", 32'(key_code), 32'h4);
        pressed = '0;
        wait_ticks(6);
        chk("multi_count", 32'(pulses - base), 32'd1);

        // clr during DEBOUNCE aborts; held key is re-accepted afterwards
        do_reset();
        base = pulses;
        pressed[2][1] = 1'b1;
        wait_ticks(3);
        do_reset();
        chk("abort_no_pulse", 32'(pulses - base), 32'd0);
        chk("abort_entry", 32'(entry_value), 32'h0);
        wait_pulse(base, 12);
        chk("reaccept_code", 32'(key_code), 32'h9);
        chk("reaccept_when", 32'(pulse_ecnt), 32'd20);
        pressed = '0;
        wait_ticks(6);
        chk("reaccept_count", 32'(pulses - base), 32'd1);

        // Key 7 held 17 ticks after acceptance
        do_reset();
        base = pulses;
        pressed[1][3] = 1'b1;
        wait_pulse(base, 12);
        wait_ticks(17);
        pressed = '0;
        wait_ticks(6);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("hold_count", 32'(pulses - base), 32'd4);
        chk("hold_entry", 32'(entry_value), 32'h7777);
`else
        chk("hold_count", 32'(pulses - base), 32'd1);
        chk("hold_entry", 32'(entry_value), 32'h0007);
`endif
        chk("hold_code", 32'(key_code), 32'h7);

        chk("no_double_pulse", 32'(doubles), 32'd0);
        chk("no_stray_update", 32'(strays), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
